// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared width helpers for the programmable-threshold sync FIFO
package sfifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Occupancy spans 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// rtl/sfifo_ram.sv - DEPTH x WIDTH storage, one write port, one asynchronous read port
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter int   WIDTH  = 8,
    parameter int   DEPTH  = 15,
    localparam int  ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sfifo_prog.sv
// rtl/sfifo_prog.sv - synchronous FIFO with programmable almost flags, sticky errors and optional FWFT
module sfifo_prog
    import sfifo_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 15,
    parameter int   FWFT  = 0,
    localparam int  CNT_W = cnt_width(DEPTH),
    localparam int  PTR_W = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             half,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rd_word;
    logic             wr_req, rd_req;
    logic             wr_acc, rd_acc;

    assign wr_req = ~write_n;
    assign rd_req = ~read_n;

    // A write into a full FIFO is still legal when a read frees a slot this cycle.
    assign rd_acc = rd_req & ~clr & ~empty;
    assign wr_acc = wr_req & ~clr & (~full | rd_acc);

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign half         = (count_q >= CNT_W'((DEPTH + 1) / 2));
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
            if (wr_req && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_req && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is the async RAM output; masked while empty so reset shows zero.
            assign data_out = empty ? '0 : rd_word;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc) begin
                    dout_d = rd_word;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: doc/sfifo_prog.md
SFIFO_PROG -- requirements
Module: sfifo_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 15, storage capacity in words (>=2, power of two not required).
REQ-003 The block SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port clr, input, 1, synchronous clear, active-high.
REQ-007 The block SHALL have port data_in, input, WIDTH, write data.
REQ-008 The block SHALL have port write_n, input, 1, write request, active-low.
REQ-009 The block SHALL have port read_n, input, 1, read request, active-low.
REQ-010 The block SHALL have port af_thresh, input, CNT_W, almost-full threshold.
REQ-011 The block SHALL have port ae_thresh, input, CNT_W, almost-empty threshold.
REQ-012 The block SHALL have port data_out, output, WIDTH, read data.
REQ-013 The block SHALL have ports full, empty, half, almost_full, almost_empty, each output, 1, status flags.
REQ-014 The block SHALL have port count, output, CNT_W, current occupancy, range 0..DEPTH.
REQ-015 The block SHALL have ports overflow, underflow, each output, 1, sticky error flags.

Function
REQ-016 Write acceptance SHALL occur when write_n=0 and clr=0 and (full=0 or a read is accepted in the same cycle).
REQ-017 Read acceptance SHALL occur when read_n=0 and clr=0 and empty=0.
REQ-018 count SHALL go +1 on write-only, -1 on read-only, and stay unchanged on both or neither.
REQ-019 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Flags SHALL be derived from the registered count: empty = count==0; full = count==DEPTH; half = count>=(DEPTH+1)/2; almost_full = count>=af_thresh; almost_empty = count<=ae_thresh.
REQ-021 With FWFT=0, data_out SHALL present the popped word one edge after read acceptance and hold its value otherwise.
REQ-022 With FWFT=1, data_out SHALL show the head word whenever empty=0; the first write into an empty FIFO SHALL be visible after one edge, and a read SHALL advance to the next word.
REQ-023 overflow SHALL set on write_n=0 with write not accepted; underflow SHALL set on read_n=0 with empty=1; both SHALL remain set until clr or reset.
REQ-024 At empty with simultaneous read and write, the write SHALL be accepted, the read rejected, and underflow set.
REQ-025 At full with simultaneous read and write, both SHALL be accepted, count stay DEPTH, and overflow not set.
REQ-026 clr SHALL take priority over read/write, zeroing pointers, count, overflow and underflow at the next edge; data_out SHALL hold in FWFT=0.

Reset
REQ-027 reset_n=0 SHALL immediately force pointers=0, count=0, data_out=0, empty=1, full=0, half=0, overflow=0, underflow=0; almost_empty=1 and almost_full=(af_thresh==0).
REQ-028 Storage array contents SHALL NOT require reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored words.

Structure
REQ-030 Shared package sfifo_pkg SHALL hold the clog2 function and the CNT_W derivation ($clog2(DEPTH+1)).
REQ-031 Storage SHALL be one sub-module, sfifo_ram: 1 write port, 1 asynchronous read port, DEPTH x WIDTH, no reset.

Verification
REQ-032 Reset: after release -> empty=1, full=0, half=0, count=0, data_out=0, overflow=0, underflow=0.
REQ-033 DEPTH=15, back-to-back writes 1..15 -> half rises at count 8, full at count 15; a 16th write -> overflow=1, count=15.
REQ-034 Read 15 words (FWFT=0) -> data_out 1..15 in order, each one edge after acceptance; extra read -> underflow=1, empty=1.
REQ-035 Simultaneous read+write at full -> count stays 15, overflow=0; at empty -> count=1, underflow=1.
REQ-036 40 interleaved writes/reads (DEPTH=15, af_thresh=12, ae_thresh=3) -> sequence intact across pointer wrap; almost flags toggle exactly at count 12 and 3.
REQ-037 FWFT=1: write 0xA5 into empty -> data_out=0xA5, empty=0 one edge later with no read; clr mid-stream -> count=0, empty=1 next edge.
